vv_add_mem_arbiter: RTL
=======================

// Module: vv_add_mem_arbiter
// PURPOSE
//  Shares the single RoCC memory port (mem_req_*/mem_resp_*) of the vv_add accelerator between
//  NUM_REQ internal requesters (e.g. load-A, load-B, store-C streams). Round-robin arbitrates
//  into a one-entry holding register, stamps a tag, tracks outstanding requests per requester
//  and routes responses/nacks back to the owning requester. busy_o feeds cc_busy_o.
// PARAMETERS
//  NUM_REQ          3   requesters, 2..4
//  MAX_OUTSTANDING  4   max in-flight requests per requester, 1..15
// PORTS
//  clk           in   1            clock, all logic on rising edge
//  rst           in   1            asynchronous, active-low reset
//  req_valid_i   in   NUM_REQ      per-requester request valid
//  req_ready_o   out  NUM_REQ      per-requester accept (at most one bit high)
//  req_addr_i    in   NUM_REQ*40   packed addresses, requester i at [40*i+:40]
//  req_cmd_i     in   NUM_REQ*5    packed mem cmd
//  req_typ_i     in   NUM_REQ*3    packed mem typ
//  req_data_i    in   NUM_REQ*64   packed store data
//  resp_valid_o  out  NUM_REQ      one-cycle pulse, non-nacked response for requester i
//  resp_nack_o   out  NUM_REQ      one-cycle pulse, nacked request for requester i
//  resp_data_o   out  64           response data, shared, valid with resp_valid_o
//  mem_req_ready_i  in   1         memory accepts request
//  mem_req_valid_o  out  1         request valid (registered)
//  mem_req_addr_o   out  40 / mem_req_tag_o out 10 / mem_req_cmd_o out 5 / mem_req_typ_o out 3
//  mem_req_phys_o   out  1         tied 0 (virtual addressing)
//  mem_req_data_o   out  64        store data
//  mem_resp_valid_i in   1 / mem_resp_tag_i in 10 / mem_resp_data_i in 64 / mem_resp_nack_i in 1
//  busy_o        out  1            holding register full or any counter nonzero
//  tag_err_o     out  1            sticky: response with unknown requester id
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, rr pointer 0, seq counter 0, outstanding counters 0, holding reg empty.
//  Eligible(i) = req_valid_i[i] && outst[i] < MAX_OUTSTANDING.
//  Slot free = !mem_req_valid_o || mem_req_ready_i (combinational path from mem_req_ready_i).
//  Grant: first eligible i scanning from rr pointer upward, wrapping; req_ready_o[i]=grant&&slot free.
//  Accept at edge t (valid&&ready): holding reg loads fields, mem_req_valid_o=1 from t+1; rr pointer
//   -> (i+1) mod NUM_REQ; no accept -> pointer unchanged. Back-to-back: one request per cycle.
//  Holding reg stable while mem_req_valid_o && !mem_req_ready_i; cleared on fire with no new accept.
//  Tag = {seq[7:0], id[1:0]}; seq increments mod 256 on each arbiter accept (wraps 255->0).
//  outst[i]: +1 on mem_req fire for id i; -1 on mem_resp_valid_i for id i (nack or not);
//   both same cycle -> unchanged. Never underflows: decrement at 0 ignored and tag_err_o set.
//  Response: mem_resp_valid_i at t, id=tag[1:0] -> at t+1 resp_valid_o[id]=!nack,
//   resp_nack_o[id]=nack, resp_data_o=mem_resp_data_i (held until next response). Store responses
//   also pulse resp_valid_o. Replay after nack is the requester's responsibility.
//  id >= NUM_REQ -> response dropped, no pulse, tag_err_o=1 until reset.
//  Reset mid-operation: in-flight request/tags abandoned; later responses with outst=0 set tag_err_o.
//  busy_o = mem_req_valid_o || |outst (combinational from registers).
// TESTING
//  1 Reset: rst=0 with all req_valid_i=1 -> all outputs 0; after release first grant to req 0, tag 0x000.
//  2 RR: req 0,1,2 valid continuously, mem_req_ready_i=1 -> mem tags 0x000,0x005,0x00A,0x00C, one per cycle.
//  3 Backpressure: mem_req_ready_i=0 for 5 cycles -> addr/tag/data stable, all req_ready_o=0; resumes on ready.
//  4 Limit: req 1 issues 4 with no responses -> req_ready_o[1]=0, req 0/2 still granted; one response -> req 1 regranted.
//  5 Resp/nack: resp tag 0x006 data 0x1234 -> next cycle resp_valid_o=3'b100, data 0x1234; nack -> resp_nack_o[2] only.
//  6 Errors: resp tag id 3 with NUM_REQ=3 -> no pulse, tag_err_o=1 sticky; simultaneous fire+resp on same id -> outst unchanged.

Source files
------------

// File: rtl/vv_add_mem_arbiter.sv
// Shares the vv_add RoCC memory port between NUM_REQ request streams and routes responses back by tag.
// Latency: an accepted request is on mem_req_* the next cycle; a memory response reaches its requester one cycle later.
// Backpressure: req_ready_o stays low while the holding register is stalled by mem_req_ready_i or a requester is at its in-flight limit.
module vv_add_mem_arbiter #(
    parameter int NUM_REQ         = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ*40-1:0] req_addr_i,
    input  logic [NUM_REQ*5-1:0]  req_cmd_i,
    input  logic [NUM_REQ*3-1:0]  req_typ_i,
    input  logic [NUM_REQ*64-1:0] req_data_i,
    output logic [NUM_REQ-1:0]    resp_valid_o,
    output logic [NUM_REQ-1:0]    resp_nack_o,
    output logic [63:0]           resp_data_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_valid_o,
    output logic [39:0]           mem_req_addr_o,
    output logic [9:0]            mem_req_tag_o,
    output logic [4:0]            mem_req_cmd_o,
    output logic [2:0]            mem_req_typ_o,
    output logic                  mem_req_phys_o,
    output logic [63:0]           mem_req_data_o,
    input  logic                  mem_resp_valid_i,
    input  logic [9:0]            mem_resp_tag_i,
    input  logic [63:0]           mem_resp_data_i,
    input  logic                  mem_resp_nack_i,
    output logic                  busy_o,
    output logic                  tag_err_o
);

    // Counters count issued (fired) requests; one accepted-but-unissued request
    // is not yet counted, so leave headroom of one above the limit.
    localparam int            CW      = $clog2(MAX_OUTSTANDING + 2);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [1:0]          rr_ptr;
    logic [7:0]          seq;
    logic [CW-1:0]       outst [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  inc_vec;
    logic [NUM_REQ-1:0]  dec_vec;
    logic [NUM_REQ-1:0]  nz_vec;
    logic                grant_vld;
    logic [1:0]          grant_id;
    logic [2:0]          scan_idx;
    logic                slot_free;
    logic                accept;
    logic                mem_fire;
    logic                resp_known;
    logic                underflow;
    logic [39:0]         sel_addr;
    logic [4:0]          sel_cmd;
    logic [2:0]          sel_typ;
    logic [63:0]         sel_data;
    logic                unused_tag_bits;

    // Upper tag bits carry the sequence number only; routing uses the id bits.
    assign unused_tag_bits = ^mem_resp_tag_i[9:2];

    assign slot_free      = !mem_req_valid_o || mem_req_ready_i;
    assign mem_fire       = mem_req_valid_o && mem_req_ready_i;
    // Grants are suppressed while reset is asserted so nothing looks accepted.
    assign accept         = grant_vld && slot_free && rst;
    assign resp_known     = ({1'b0, mem_resp_tag_i[1:0]} < 3'(NUM_REQ));
    assign underflow      = |(dec_vec & ~inc_vec & ~nz_vec);
    assign busy_o         = mem_req_valid_o || (|nz_vec);
    assign mem_req_phys_o = 1'b0;

    // Per-requester eligibility and counter increment/decrement strobes.
    always_comb begin
        eligible = '0;
        nz_vec   = '0;
        inc_vec  = '0;
        dec_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid_i[i] && (outst[i] < MAX_CNT);
            nz_vec[i]   = (outst[i] != '0);
            inc_vec[i]  = mem_fire && (mem_req_tag_o[1:0] == 2'(i));
            dec_vec[i]  = mem_resp_valid_i && (mem_resp_tag_i[1:0] == 2'(i));
        end
    end

    // Round-robin scan: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + 3'(k);
            if (scan_idx >= 3'(NUM_REQ)) begin
                scan_idx = scan_idx - 3'(NUM_REQ);
            end
            if (!grant_vld && eligible[scan_idx[1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx[1:0];
            end
        end
    end

    // Mux the granted requester's fields toward the holding register.
    always_comb begin
        sel_addr = '0;
        sel_cmd  = '0;
        sel_typ  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_addr = req_addr_i[40*i +: 40];
                sel_cmd  = req_cmd_i[5*i +: 5];
                sel_typ  = req_typ_i[3*i +: 3];
                sel_data = req_data_i[64*i +: 64];
            end
        end
    end

    // One-hot accept toward the granted requester.
    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[grant_id] = 1'b1;
        end
    end

    // Round-robin pointer moves past the winner; sequence number stamps each accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            seq    <= '0;
        end else if (accept) begin
            rr_ptr <= (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
            seq    <= seq + 8'd1;
        end
    end

    // Holding register: loads on accept, holds while stalled, empties on fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_tag_o   <= '0;
            mem_req_cmd_o   <= '0;
            mem_req_typ_o   <= '0;
            mem_req_data_o  <= '0;
        end else if (accept) begin
            mem_req_valid_o <= 1'b1;
            mem_req_addr_o  <= sel_addr;
            mem_req_tag_o   <= {seq, grant_id};
            mem_req_cmd_o   <= sel_cmd;
            mem_req_typ_o   <= sel_typ;
            mem_req_data_o  <= sel_data;
        end else if (mem_fire) begin
            mem_req_valid_o <= 1'b0;
        end
    end

    // In-flight counters: fire adds, response removes, both together cancel, never below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outst[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    outst[i] <= outst[i] + CW'(1);
                end else if (dec_vec[i] && !inc_vec[i] && nz_vec[i]) begin
                    outst[i] <= outst[i] - CW'(1);
                end
            end
        end
    end

    // Response routing to the owning requester and the sticky tag error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_o <= '0;
            resp_nack_o  <= '0;
            resp_data_o  <= '0;
            tag_err_o    <= 1'b0;
        end else begin
            resp_valid_o <= '0;
            resp_nack_o  <= '0;
            if (mem_resp_valid_i && resp_known) begin
                if (mem_resp_nack_i) begin
                    resp_nack_o <= dec_vec;
                end else begin
                    resp_valid_o <= dec_vec;
                end
                resp_data_o <= mem_resp_data_i;
            end
            if ((mem_resp_valid_i && !resp_known) || underflow) begin
                tag_err_o <= 1'b1;
            end
        end
    end

endmodule
